rom_fetch_unit: RTL
===================

Name: rom_fetch_unit

Overview:
- Read-side initiator for the 128x8 program ROM.
- Drives ROM addresses from its own program counter and captures the ROM's registered read data (1-cycle latency).
- Assembles 1- or 2-byte instructions (opcode plus optional operand) and presents them downstream on a valid/ready handshake.
- Accepts branch redirects and flags fetches outside the 128-entry ROM.

Parameters:
- ADDR_W, 8, ROM address / PC width
- DATA_W, 8, ROM data width
- ROM_DEPTH, 128, number of valid ROM locations; addresses >= ROM_DEPTH are out of range
- RESET_PC, 0, PC and ROM address after reset

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- rom_address  out  ADDR_W  registered address to ROM
- rom_data_in  in  DATA_W  ROM read data; valid the cycle after rom_address is presented
- instr_valid  out  1  instruction bundle valid
- instr_ready  in  1  downstream accepts bundle
- instr_opcode  out  DATA_W  opcode byte
- instr_operand  out  DATA_W  operand byte; 0 for 1-byte instructions
- instr_pc  out  ADDR_W  address of opcode
- instr_len  out  1  0 = 1 byte, 1 = 2 bytes
- redirect_valid  in  1  load new PC
- redirect_addr  in  ADDR_W  redirect target
- fetch_fault  out  1  sticky out-of-range fetch flag
- instr_count  out  16  present only under FETCH_PERF_CNT_EN

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pc = rom_address = RESET_PC.
  - state = REQ_OP.
  - instr_valid, instr_opcode, instr_operand, instr_pc, instr_len, fetch_fault all 0.
  - Reset applied mid-operation discards all in-flight work.
- FSM states:
  - REQ_OP: rom_address = pc, which the ROM samples at this edge. If pc >= ROM_DEPTH, go to FAULT. Otherwise rom_address <= pc+1 (speculative operand address) and go to CAP_OP.
  - CAP_OP: latch instr_opcode = rom_data_in and instr_pc = pc.
    - Length decoded from the opcode.
    - 1-byte: instr_operand <= 0, go to PRESENT.
    - 2-byte: if pc+1 >= ROM_DEPTH, go to FAULT; else go to CAP_OPD.
  - CAP_OPD: latch instr_operand = rom_data_in, go to PRESENT.
  - PRESENT: instr_valid = 1. Opcode, operand, pc and len are held stable while instr_ready = 0; no new ROM reads.
    - On valid&&ready: pc <= pc + 1 + instr_len (mod 2^ADDR_W), rom_address <= the same value, instr_valid <= 0, go to REQ_OP.
  - FAULT: fetch_fault = 1, instr_valid = 0. Exit only via redirect or reset.
- Latency: first instr_valid appears 2 cycles after reset release for a 1-byte instruction, 3 cycles for a 2-byte instruction. With instr_ready held at 1, throughput is 3 cycles per 1-byte instruction and 4 cycles per 2-byte instruction.
- Length decode: 2-byte opcodes are 0x86, 0x8B, 0x96, 0x97, 0x20. All other opcodes are 1 byte.
- Redirect has top priority in every state:
  - pc <= redirect_addr, rom_address <= redirect_addr, instr_valid <= 0, fetch_fault <= 0, go to REQ_OP.
  - Any partially fetched instruction is discarded.
  - Redirect in the same cycle as a PRESENT handshake: the handshake counts as consumed, and redirect_addr overrides pc+len.
- PC wrap: 255 + 1 wraps to 0. Any pc in 128..255 faults at REQ_OP.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - instr_count[15:0] exists.
  - Increments on each valid&&ready handshake and saturates at 0xFFFF.
  - Cleared by reset only; redirect does not clear it.
- Not defined: no instr_count port and no counter logic.

Decomposition:
- Package fetch_pkg holds:
  - the state enum {REQ_OP, CAP_OP, CAP_OPD, PRESENT, FAULT};
  - opcode constants OP_LDAA_IMM = 0x86, OP_ADDA_IMM = 0x8B, OP_LDAA_DIR = 0x96, OP_STAA_DIR = 0x97, OP_BRA = 0x20;
  - function is_two_byte(opcode).
- One natural sub-module: fetch_len_decode, a combinational opcode-to-length decoder used by CAP_OP.

Test Plan:
- Bench ROM model: 1-cycle registered read; holds 86 AA 96 E0 20 00 at addresses 0-5, 0x01 elsewhere.
- Reset, ready=1 -> bundles {pc0, 86, AA, len1} valid in cycle 3, {pc2, 96, E0, len1} in cycle 7, {pc4, 20, 00, len1} in cycle 11, then {pc6, 01, 00, len0} in cycle 14 (cycles counted from 0 at reset release).
- Hold ready=0 for 5 cycles at the first bundle -> outputs stable at {0, 86, AA}; rom_address stays 1; on accept, next REQ_OP presents 2.
- redirect_valid with addr=4 in cycle 2 (CAP_OPD) -> AA discarded; next bundle is {pc4, 20, 00}, valid in cycle 6.
- Redirect to 2 in the same cycle as the first handshake -> next bundle pc=2; fetch_fault stays 0.
- ROM[127]=0x86, redirect to 127 -> fetch_fault=1, no instr_valid; redirect to 0 -> fault clears, bundle {pc0, 86, AA}.
- With FETCH_PERF_CNT_EN: 3 handshakes -> instr_count=3; rst_n=0 mid-PRESENT -> count=0, instr_valid=0, rom_address=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the ROM fetch unit:
//   - fetch_state_e : fetch FSM state encoding
//   - OP_*          : opcodes that carry a one-byte operand
//   - is_two_byte() : returns 1 when an opcode is followed by an operand byte
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    REQ_OP,
    CAP_OP,
    CAP_OPD,
    PRESENT,
    FAULT
  } fetch_state_e;

  localparam logic [7:0] OP_LDAA_IMM = 8'h86;
  localparam logic [7:0] OP_ADDA_IMM = 8'h8B;
  localparam logic [7:0] OP_LDAA_DIR = 8'h96;
  localparam logic [7:0] OP_STAA_DIR = 8'h97;
  localparam logic [7:0] OP_BRA      = 8'h20;

  // Every opcode not listed here is a single-byte instruction.
  function automatic logic is_two_byte(input logic [7:0] opcode);
    case (opcode)
      OP_LDAA_IMM,
      OP_ADDA_IMM,
      OP_LDAA_DIR,
      OP_STAA_DIR,
      OP_BRA:   return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// ---------------------------------------------------------------------------
// fetch_len_decode
// Combinational opcode-to-length decoder used when the opcode byte is
// captured from the ROM.
// Ports:
//   i_opcode  in   8  opcode byte straight from the ROM read data
//   o_len     out  1  0 = 1-byte instruction, 1 = 2-byte instruction
// ---------------------------------------------------------------------------
module fetch_len_decode
  import fetch_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic       o_len
);

  assign o_len = is_two_byte(i_opcode);

endmodule

// File: rtl/rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// rom_fetch_unit
// Read-side initiator for the 128x8 program ROM. Walks the program counter,
// captures the ROM's registered read data, assembles 1- or 2-byte
// instructions and hands them downstream on a valid/ready handshake.
// Branch redirects reload the PC; fetches beyond the ROM raise a sticky
// fault that only a redirect or reset clears.
//
// Optional build macro: FETCH_PERF_CNT_EN adds the instr_count port and a
// saturating counter of accepted instructions.
//
// Ports:
//   clk             in   1       rising-edge clock
//   rst_n           in   1       synchronous active-low reset
//   rom_address     out  ADDR_W  registered ROM read address
//   rom_data_in     in   DATA_W  ROM data, one cycle after rom_address
//   instr_valid     out  1       instruction bundle valid
//   instr_ready     in   1       downstream accepts bundle
//   instr_opcode    out  DATA_W  opcode byte
//   instr_operand   out  DATA_W  operand byte (0 for 1-byte instructions)
//   instr_pc        out  ADDR_W  address of the opcode
//   instr_len       out  1       0 = 1 byte, 1 = 2 bytes
//   redirect_valid  in   1       load a new PC
//   redirect_addr   in   ADDR_W  redirect target
//   fetch_fault     out  1       sticky out-of-range fetch flag
//   instr_count     out  16      accepted-instruction count (macro only)
// ---------------------------------------------------------------------------
module rom_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                ROM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data_in,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_len,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  localparam logic [ADDR_W:0] DEPTH_WIDE = (ADDR_W+1)'(ROM_DEPTH);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_rom_address;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [DATA_W-1:0] r_instr_opcode;
  logic [DATA_W-1:0] r_instr_operand;
  logic              r_instr_valid;
  logic              r_instr_len;
  logic              r_fetch_fault;

  logic              w_two_byte;
  logic              w_handshake;
  logic [ADDR_W:0]   w_pc_wide;
  logic              w_pc_out_of_range;
  logic              w_opd_out_of_range;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_pc_next;

  fetch_len_decode u_len_decode (
    .i_opcode (rom_data_in[7:0]),
    .o_len    (w_two_byte)
  );

  // Range checks use one extra bit so pc+1 never wraps back into range.
  assign w_pc_wide          = {1'b0, r_pc};
  assign w_pc_out_of_range  = (w_pc_wide >= DEPTH_WIDE);
  assign w_opd_out_of_range = ((w_pc_wide + (ADDR_W+1)'(1)) >= DEPTH_WIDE);

  // Sequential PC arithmetic wraps modulo 2^ADDR_W.
  assign w_pc_plus1  = r_pc + ADDR_W'(1);
  assign w_pc_next   = r_pc + ADDR_W'(1) + ADDR_W'(r_instr_len);
  assign w_handshake = r_instr_valid & instr_ready;

  // Fetch FSM. rom_address already equals pc on entry to REQ_OP, so the ROM
  // samples the opcode address there; the operand address is then issued
  // speculatively so its data lines up with CAP_OPD. Redirect outranks
  // everything, including a handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= REQ_OP;
      r_pc            <= RESET_PC;
      r_rom_address   <= RESET_PC;
      r_instr_valid   <= 1'b0;
      r_instr_opcode  <= '0;
      r_instr_operand <= '0;
      r_instr_pc      <= '0;
      r_instr_len     <= 1'b0;
      r_fetch_fault   <= 1'b0;
    end else if (redirect_valid) begin
      r_pc          <= redirect_addr;
      r_rom_address <= redirect_addr;
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_state       <= REQ_OP;
    end else begin
      case (r_state)
        REQ_OP: begin
          if (w_pc_out_of_range) begin
            r_fetch_fault <= 1'b1;
            r_state       <= FAULT;
          end else begin
            r_rom_address <= w_pc_plus1;
            r_state       <= CAP_OP;
          end
        end
        CAP_OP: begin
          r_instr_opcode <= rom_data_in;
          r_instr_pc     <= r_pc;
          r_instr_len    <= w_two_byte;
          if (!w_two_byte) begin
            r_instr_operand <= '0;
            r_instr_valid   <= 1'b1;
            r_state         <= PRESENT;
          end else if (w_opd_out_of_range) begin
            r_fetch_fault <= 1'b1;
            r_state       <= FAULT;
          end else begin
            r_state <= CAP_OPD;
          end
        end
        CAP_OPD: begin
          r_instr_operand <= rom_data_in;
          r_instr_valid   <= 1'b1;
          r_state         <= PRESENT;
        end
        PRESENT: begin
          if (w_handshake) begin
            r_pc          <= w_pc_next;
            r_rom_address <= w_pc_next;
            r_instr_valid <= 1'b0;
            r_state       <= REQ_OP;
          end
        end
        FAULT: begin
          r_fetch_fault <= 1'b1;
          r_instr_valid <= 1'b0;
        end
        default: r_state <= REQ_OP;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_instr_count;

  // Counts accepted bundles (a handshake coinciding with a redirect still
  // counts); saturates instead of wrapping and ignores redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr_count <= '0;
    end else if (w_handshake && (r_instr_count != 16'hFFFF)) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign instr_count = r_instr_count;
`endif

  assign rom_address   = r_rom_address;
  assign instr_valid   = r_instr_valid;
  assign instr_opcode  = r_instr_opcode;
  assign instr_operand = r_instr_operand;
  assign instr_pc      = r_instr_pc;
  assign instr_len     = r_instr_len;
  assign fetch_fault   = r_fetch_fault;

endmodule
